// File: rtl/load_store_unit.sv
// Load/store unit: accepts one CPU access at a time, does aligned loads with
// sign/zero extension and sub-doubleword stores as read-modify-write.
module load_store_unit #(
    parameter int unsigned WORD = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [1:0]      req_size,
    input  logic            req_signed,
    input  logic [WORD-1:0] req_addr,
    input  logic [WORD-1:0] req_wdata,
    output logic            resp_valid,
    output logic [WORD-1:0] resp_rdata,
    output logic            resp_error,
    output logic [WORD-1:0] mem_address,
    output logic            mem_read,
    output logic            mem_write,
    output logic [WORD-1:0] mem_write_data,
    input  logic [WORD-1:0] mem_read_data
);

    localparam int unsigned OFF_W = 3;
    localparam int unsigned SHAMT_W = OFF_W + 3;

    typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RESP} state_t;

    state_t            state;
    logic              write_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [WORD-1:0]   addr_q;
    logic [WORD-1:0]   wdata_q;

    logic              misaligned_c;
    logic [SHAMT_W-1:0] shamt_c;
    logic [WORD-1:0]   size_mask_c;
    logic [WORD-1:0]   lane_c;
    logic [WORD-1:0]   load_c;
    logic [WORD-1:0]   merge_c;

    // Strobes and handshake decode straight from the state register
    assign req_ready   = (state == IDLE);
    assign resp_valid  = (state == RESP);
    assign mem_read    = (state == RD);
    assign mem_write   = (state == WR);
    assign mem_address = {addr_q[WORD-1:OFF_W], {OFF_W{1'b0}}};

    always_comb begin
        misaligned_c = 1'b0;
        case (req_size)
            2'd0:    misaligned_c = 1'b0;
            2'd1:    misaligned_c = req_addr[0];
            2'd2:    misaligned_c = |req_addr[1:0];
            default: misaligned_c = |req_addr[2:0];
        endcase
    end

    // Lane extraction, extension and store merge for the captured request
    always_comb begin
        shamt_c     = {addr_q[OFF_W-1:0], 3'b000};
        size_mask_c = '1;
        case (size_q)
            2'd0:    size_mask_c = {{(WORD-8){1'b0}},  8'hFF};
            2'd1:    size_mask_c = {{(WORD-16){1'b0}}, 16'hFFFF};
            2'd2:    size_mask_c = {{(WORD-32){1'b0}}, 32'hFFFF_FFFF};
            default: size_mask_c = '1;
        endcase
        lane_c = (mem_read_data >> shamt_c) & size_mask_c;
        load_c = lane_c;
        if (signed_q) begin
            case (size_q)
                2'd0:    load_c = {{(WORD-8){lane_c[7]}},   lane_c[7:0]};
                2'd1:    load_c = {{(WORD-16){lane_c[15]}}, lane_c[15:0]};
                2'd2:    load_c = {{(WORD-32){lane_c[31]}}, lane_c[31:0]};
                default: load_c = lane_c;
            endcase
        end
        merge_c = (mem_read_data & ~(size_mask_c << shamt_c))
                | ((wdata_q & size_mask_c) << shamt_c);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            write_q        <= 1'b0;
            size_q         <= 2'd0;
            signed_q       <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            resp_rdata     <= '0;
            resp_error     <= 1'b0;
            mem_write_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q    <= req_write;
                        size_q     <= req_size;
                        signed_q   <= req_signed;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        resp_rdata <= '0;
                        if (misaligned_c) begin
                            resp_error <= 1'b1;
                            state      <= RESP;
                        end else begin
                            resp_error <= 1'b0;
                            if (req_write && (req_size == 2'd3)) begin
                                mem_write_data <= req_wdata;
                                state          <= WR;
                            end else begin
                                state <= RD;
                            end
                        end
                    end
                end
                RD:      state <= RD_WAIT;
                RD_WAIT: begin
                    if (write_q) begin
                        mem_write_data <= merge_c;
                        state          <= WR;
                    end else begin
                        resp_rdata <= load_c;
                        state      <= RESP;
                    end
                end
                WR:      state <= RESP;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small behavioural data memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_error;
    logic [63:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_write_data;
    logic [63:0] mem_read_data;

    load_store_unit #(.WORD(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .mem_address(mem_address), .mem_read(mem_read),
        .mem_write(mem_write), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [16];
    logic [63:0] wr_log [64];
    logic        poke_en = 1'b0;
    logic [3:0]  poke_idx = 4'd0;
    logic [63:0] poke_val = 64'd0;
    int rd_cnt = 0, wr_cnt = 0, rv_cnt = 0, both_cnt = 0;
    int n_vec = 0, n_err = 0;

    // Memory answers the cycle after mem_read is sampled
    always @(posedge clk) begin
        if (poke_en) mem[poke_idx] <= poke_val;
        else if (mem_write) mem[mem_address[6:3]] <= mem_write_data;
        if (mem_read) mem_read_data <= mem[mem_address[6:3]];
        if (mem_read) rd_cnt <= rd_cnt + 1;
        if (mem_write) begin
            wr_log[wr_cnt[5:0]] <= mem_write_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (resp_valid) rv_cnt <= rv_cnt + 1;
        if (mem_read && mem_write) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [3:0] idx, input logic [63:0] val);
        @(negedge clk);
        poke_en = 1'b1; poke_idx = idx; poke_val = val;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [63:0] a, input logic [63:0] wd,
                           output int lat, output logic [63:0] rd, output logic err);
        int budget;
        @(negedge clk);
        req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        budget = 20;
        while (!req_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; rd = '0; err = 1'b0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (resp_valid) begin
                rd = resp_rdata;
                err = resp_error;
                break;
            end
        end
    endtask

    initial begin
        int lat, r0, w0, v0;
        logic [63:0] rd;
        logic err;
        logic seen;

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_error", 64'(resp_error), 64'd0);
        check("rst_rdata", resp_rdata, 64'd0);
        check("rst_wdata", mem_write_data, 64'd0);
        check("rst_strobes", 64'({mem_read, mem_write}), 64'd0);
        reset = 1'b0;

        // Doubleword load
        poke(4'd2, 64'h1122334455667788);
        r0 = rd_cnt; w0 = wr_cnt;
        run_req(1'b0, 2'd3, 1'b0, 64'h10, 64'd0, lat, rd, err);
        check("ld64_lat", 64'(lat), 64'd3);
        check("ld64_data", rd, 64'h1122334455667788);
        check("ld64_err", 64'(err), 64'd0);
        check("ld64_reads", 64'(rd_cnt - r0), 64'd1);
        check("ld64_writes", 64'(wr_cnt - w0), 64'd0);

        run_req(1'b0, 2'd0, 1'b1, 64'h17, 64'd0, lat, rd, err);
        check("ldb_pos_signed", rd, 64'h11);
        run_req(1'b0, 2'd2, 1'b1, 64'h14, 64'd0, lat, rd, err);
        check("ldw_hi", rd, 64'h11223344);
        run_req(1'b0, 2'd1, 1'b0, 64'h12, 64'd0, lat, rd, err);
        check("ldh_mid", rd, 64'h5566);

        poke(4'd2, 64'h8000000000000000);
        run_req(1'b0, 2'd0, 1'b1, 64'h17, 64'd0, lat, rd, err);
        check("ldb_neg_signed", rd, 64'hFFFFFFFFFFFFFF80);
        run_req(1'b0, 2'd0, 1'b0, 64'h17, 64'd0, lat, rd, err);
        check("ldb_neg_unsigned", rd, 64'h80);
        run_req(1'b0, 2'd3, 1'b1, 64'h10, 64'd0, lat, rd, err);
        check("ld64_ignores_signed", rd, 64'h8000000000000000);

        // Halfword read-modify-write store
        poke(4'd1, 64'hAAAAAAAAAAAAAAAA);
        r0 = rd_cnt; w0 = wr_cnt;
        run_req(1'b1, 2'd1, 1'b0, 64'h0A, 64'h1234, lat, rd, err);
        check("sth_lat", 64'(lat), 64'd4);
        check("sth_reads", 64'(rd_cnt - r0), 64'd1);
        check("sth_writes", 64'(wr_cnt - w0), 64'd1);
        check("sth_wdata", wr_log[w0[5:0]], 64'hAAAAAAAA1234AAAA);
        check("sth_mem", mem[1], 64'hAAAAAAAA1234AAAA);
        check("sth_rdata", rd, 64'd0);

        // Doubleword store goes straight to WR
        r0 = rd_cnt; w0 = wr_cnt;
        run_req(1'b1, 2'd3, 1'b0, 64'h30, 64'hDEADBEEFCAFEF00D, lat, rd, err);
        check("std_lat", 64'(lat), 64'd2);
        check("std_reads", 64'(rd_cnt - r0), 64'd0);
        check("std_mem", mem[6], 64'hDEADBEEFCAFEF00D);

        // Misaligned accesses
        r0 = rd_cnt; w0 = wr_cnt;
        run_req(1'b0, 2'd2, 1'b0, 64'h06, 64'd0, lat, rd, err);
        check("mis_lat", 64'(lat), 64'd1);
        check("mis_err", 64'(err), 64'd1);
        check("mis_rdata", rd, 64'd0);
        run_req(1'b1, 2'd1, 1'b0, 64'h0B, 64'hFFFF, lat, rd, err);
        check("mis_st_err", 64'(err), 64'd1);
        check("mis_strobes", 64'((rd_cnt - r0) + (wr_cnt - w0)), 64'd0);
        check("mis_mem", mem[1], 64'hAAAAAAAA1234AAAA);

        // Back-to-back stores with req_valid held high
        poke(4'd4, 64'h0);
        w0 = wr_cnt;
        @(negedge clk);
        req_write = 1'b1; req_size = 2'd1; req_signed = 1'b0; req_addr = 64'h20;
        req_wdata = 64'h1111; req_valid = 1'b1;
        @(posedge clk);
        #1 req_wdata = 64'h2222;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen = seen | req_ready;
        end
        check("b2b_busy_ready", 64'(seen), 64'd0);
        check("b2b_resp1", 64'(resp_valid), 64'd1);
        @(negedge clk);
        check("b2b_ready_idle", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (lat < 20 && !resp_valid) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_lat2", 64'(lat), 64'd4);
        check("b2b_writes", 64'(wr_cnt - w0), 64'd2);
        check("b2b_first", wr_log[w0[5:0]], 64'h1111);
        check("b2b_second", wr_log[(w0 + 1) & 63], 64'h2222);
        check("b2b_mem", mem[4], 64'h2222);

        // Reset while a byte store sits in RD_WAIT
        poke(4'd5, 64'h0123456789ABCDEF);
        w0 = wr_cnt; v0 = rv_cnt;
        @(negedge clk);
        req_write = 1'b1; req_size = 2'd0; req_addr = 64'h29; req_wdata = 64'h55;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_ready", 64'(req_ready), 64'd1);
        check("rst_mid_strobes", 64'({mem_read, mem_write}), 64'd0);
        repeat (5) @(negedge clk);
        check("rst_mid_writes", 64'(wr_cnt - w0), 64'd0);
        check("rst_mid_resp", 64'(rv_cnt - v0), 64'd0);
        check("rst_mid_mem", mem[5], 64'h0123456789ABCDEF);

        // Unit recovers after the abort
        run_req(1'b0, 2'd0, 1'b0, 64'h29, 64'd0, lat, rd, err);
        check("post_rst_load", rd, 64'hCD);
        check("strobe_excl", 64'(both_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: WORD, 64, datapath and address width in bits.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  CPU access request present.
REQ-005 req_ready  output  1  unit can accept a request; high only in IDLE.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  access size: 0 byte, 1 half, 2 word (32b), 3 doubleword.
REQ-008 req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-009 req_addr  input  WORD  byte address.
REQ-010 req_wdata  input  WORD  store data, right-justified.
REQ-011 resp_valid  output  1  one-cycle pulse on access completion.
REQ-012 resp_rdata  output  WORD  load result; 0 for stores and errors.
REQ-013 resp_error  output  1  valid with resp_valid; 1 = misaligned, no memory access.
REQ-014 mem_address  output  WORD  doubleword-aligned address {req_addr[WORD-1:3],3'b000}.
REQ-015 mem_read  output  1  read strobe to data memory.
REQ-016 mem_write  output  1  write strobe to data memory.
REQ-017 mem_write_data  output  WORD  full doubleword to write.
REQ-018 mem_read_data  input  WORD  memory read data, valid one cycle after the edge sampling mem_read=1.

Function
REQ-019 Handshake: request accepted at a posedge where req_valid && req_ready; all req_* fields captured into registers at that edge and held until completion.
REQ-020 FSM states: IDLE, RD, RD_WAIT, WR, RESP; mem_read = (state==RD), mem_write = (state==WR), both decoded from registered state only.
REQ-021 IDLE -> ERR path: misaligned request (req_addr mod 2^req_size != 0) -> RESP with resp_error=1, no mem strobe asserted.
REQ-022 IDLE -> RD for loads and for stores with size 0-2 (read-modify-write); IDLE -> WR for doubleword stores.
REQ-023 RD -> RD_WAIT unconditionally (one cycle, mem_read=1).
REQ-024 RD_WAIT: load -> extract lane, extend, register into resp_rdata, -> RESP; store -> merge req_wdata lane into mem_read_data, register as mem_write_data, -> WR.
REQ-025 WR -> RESP (one cycle, mem_write=1); RESP -> IDLE with resp_valid=1 during RESP only.
REQ-026 Lanes little-endian: byte offset k=req_addr[2:0]; size-n field occupies bits [8k+8*2^n-1 : 8k]; non-target bytes of a RMW store unchanged.
REQ-027 Extension: size 3 loads ignore req_signed; sizes 0-2 fill upper bits with 0 or field MSB per req_signed.
REQ-028 Latency from accept edge to resp_valid cycle: load 3 cycles, dword store 2, sub-dword store 4, misaligned 1.
REQ-029 mem_address, mem_write_data hold stable whenever mem_read or mem_write is 1; mem_read and mem_write never both 1.
REQ-030 req_valid while not in IDLE is ignored (not accepted, not queued).
REQ-031 Address wraparound not special-cased: mem_address derived solely per REQ-014.

Reset
REQ-032 reset=1 at a posedge forces state IDLE, resp_valid=0, resp_error=0, resp_rdata=0, mem_write_data=0, captured request registers 0; reset takes priority over any handshake at that edge.
REQ-033 Reset mid-operation aborts the access: no resp_valid pulse, mem_read/mem_write low from the cycle after the reset edge; a pending WR does not occur if reset is sampled in the same edge that would enter WR.

Verification
REQ-034 Load dword: memory dword @0x10 = 0x1122334455667788, load size 3 addr 0x10 -> mem_read one cycle, resp_rdata=0x1122334455667788, resp_valid 3 cycles after accept, resp_error=0.
REQ-035 Signed byte load: same dword, addr 0x17 size 0 signed -> resp_rdata=0x0000000000000011; dword 0x80..., addr 0x17 size 0 signed -> 0xFFFFFFFFFFFFFF80; unsigned -> 0x0000000000000080.
REQ-036 Halfword RMW store: dword @0x8 = 0xAAAAAAAAAAAAAAAA, store size 1 addr 0xA wdata 0x1234 -> one mem_read then one mem_write with mem_write_data=0xAAAAAAAA1234AAAA, resp_valid 4 cycles after accept.
REQ-037 Misaligned: load size 2 addr 0x6 -> resp_valid next cycle with resp_error=1, resp_rdata=0, mem_read and mem_write never asserted.
REQ-038 Back-to-back with busy: req_valid held high for two stores; second accepted only after first RESP (req_ready low in RD/RD_WAIT/WR/RESP); both writes land in order.
REQ-039 Reset in RD_WAIT of a byte store -> no mem_write, no resp_valid, req_ready=1 the cycle after the reset edge, memory contents unchanged.
